// File: rtl/skew_feed_ctrl.sv
// skew_feed_ctrl: reads one tile of vectors into the skew bank, then flushes it with zero vectors
module skew_feed_ctrl #(
   parameter int N       = 4,
   parameter int ADDR_W  = 8,
   parameter int DRAIN_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] k_len,
   input  logic [ADDR_W-1:0] base,
   input  logic              stall,
   input  logic              abort,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              skew_en,
   output logic              zero_sel,
   output logic              busy,
   output logic              done
);
   typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(2 * N - 2);
   state_t state, state_nx;
   logic [ADDR_W-1:0] k_len_q, base_q, cnt;
   logic [DRAIN_W-1:0] dcnt;
   logic pend;
   // state register
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nx;
   // next state; abort overrides everything, stall freezes all but DONE
   always_comb begin
      state_nx = state;
      if (abort) state_nx = IDLE;
      else
         case (state)
            IDLE:    if (start && !stall) state_nx = (k_len == '0) ? DONE : FEED;
            FEED:    if (!stall && cnt == k_len_q) state_nx = DRAIN;
            DRAIN:   if (!stall && dcnt == DRAIN_LAST) state_nx = DONE;
            default: state_nx = IDLE;
         endcase
   end
   // outputs; pend marks a buffer word read last cycle and not yet pushed into the bank
   always_comb begin
      rd_en    = state == FEED && cnt < k_len_q && !stall;
      rd_addr  = state == FEED ? base_q + cnt : '0;
      skew_en  = !stall && ((state == FEED && pend) || state == DRAIN);
      zero_sel = state == DRAIN;
      busy     = state != IDLE;
      done     = state == DONE;
   end
   // tile registers and progress counters
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         k_len_q <= '0;
         base_q  <= '0;
         cnt     <= '0;
         dcnt    <= '0;
         pend    <= 1'b0;
      end else if (abort) begin
         cnt  <= '0;
         dcnt <= '0;
         pend <= 1'b0;
      end else if (state == IDLE && start && !stall) begin
         k_len_q <= k_len;
         base_q  <= base;
         cnt     <= '0;
         dcnt    <= '0;
         pend    <= 1'b0;
      end else if (!stall) begin
         cnt  <= cnt + ADDR_W'(rd_en);
         pend <= rd_en;
         dcnt <= dcnt + DRAIN_W'(state == DRAIN);
      end
endmodule

// File: tb/tb_skew_feed_ctrl.sv
// tb_skew_feed_ctrl: directed and random tiles checked against a vector-count model of the feeder
module tb_skew_feed_ctrl;
   localparam int N = 4;
   localparam int M_IDLE = 0, M_FEED = 1, M_DRAIN = 2, M_DONE = 3;
   logic clk = 0, rst = 1, start = 0, stall = 0, abort = 0;
   logic [7:0] k_len = 0, base = 0;
   logic rd_en, skew_en, zero_sel, busy, done;
   logic [7:0] rd_addr;
   int tests = 0, fails = 0, cyc = 0, s = 0;
   int ph = 0, mk = 0, mb = 0, mi = 0, mc = 0, md = 0;
   int done_rel, first_rd, first_sk, nrd, nsk;
   logic [7:0] addrs [8];

   always #5 clk = ~clk;

   skew_feed_ctrl #(.N(N), .ADDR_W(8), .DRAIN_W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .k_len(k_len), .base(base),
      .stall(stall), .abort(abort), .rd_en(rd_en), .rd_addr(rd_addr),
      .skew_en(skew_en), .zero_sel(zero_sel), .busy(busy), .done(done)
   );

   task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
      end
   endtask

   // mi = vectors read, mc = vectors pushed into the bank, md = zero vectors pushed
   task automatic model_step();
      bit e_rd, e_sk;
      int i0;
      if (rd_en) begin
         if (first_rd < 0) first_rd = cyc - s;
         if (nrd < 8) addrs[nrd] = rd_addr;
         nrd++;
      end
      if (skew_en) begin
         if (first_sk < 0) first_sk = cyc - s;
         nsk++;
      end
      if (done) done_rel = cyc - s;
      if (rst) begin
         chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_rd_en", rd_en, 0);
         chk("rst_skew_en", skew_en, 0); chk("rst_zero_sel", zero_sel, 0); chk("rst_rd_addr", rd_addr, 0);
         ph = M_IDLE; mi = 0; mc = 0; md = 0;
         return;
      end
      e_rd = ph == M_FEED && mi < mk && !stall;
      e_sk = !stall && ((ph == M_FEED && mi > mc) || ph == M_DRAIN);
      chk("busy", busy, ph != M_IDLE);
      chk("done", done, ph == M_DONE);
      chk("rd_en", rd_en, e_rd);
      chk("skew_en", skew_en, e_sk);
      chk("zero_sel", zero_sel, ph == M_DRAIN);
      if (e_rd) chk("rd_addr", rd_addr, (mb + mi) % 256);
      if (ph == M_IDLE) chk("idle_rd_addr", rd_addr, 0);
      if (abort) begin
         ph = M_IDLE; mi = 0; mc = 0; md = 0;
      end else
         case (ph)
            M_IDLE: if (start && !stall) begin
               mk = k_len; mb = base; mi = 0; mc = 0; md = 0;
               ph = (mk == 0) ? M_DONE : M_FEED;
            end
            M_FEED: if (!stall) begin
               i0 = mi; mi += e_rd; mc += e_sk;
               if (i0 == mk && mc == mk) ph = M_DRAIN;
            end
            M_DRAIN: if (!stall) begin
               md++;
               if (md == 2 * N - 1) ph = M_DONE;
            end
            default: ph = M_IDLE;
         endcase
   endtask

   task automatic step();
      @(negedge clk);
      model_step();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   // start at cycle 0 of the tile; stall/abort/duplicate start on the given relative cycles
   task automatic tile(input logic [7:0] bb, input logic [7:0] kk, input int stc, input int abc, input int dup);
      done_rel = -1; first_rd = -1; first_sk = -1; nrd = 0; nsk = 0;
      s = cyc; start = 1; base = bb; k_len = kk; stall = 0; abort = 0;
      for (int j = 1; j <= 60; j++) begin
         step();
         start = (j == dup); base = 8'($urandom); k_len = 8'($urandom);
         stall = (j == stc); abort = (j == abc);
         if (j >= 2 && !busy) begin
            start = 0; stall = 0; abort = 0;
            return;
         end
      end
      chk("tile_timeout", 1, 0);
      start = 0; stall = 0; abort = 0;
   endtask

   initial begin
      repeat (3) step();
      rst = 0;
      step();
      chk("post_reset_busy", busy, 0);
      tile(8'h10, 8'd3, -1, -1, 2);
      chk("t1_done_cycle", done_rel, 12); chk("t1_first_rd", first_rd, 1);
      chk("t1_first_skew", first_sk, 2); chk("t1_reads", nrd, 3); chk("t1_skews", nsk, 10);
      chk("t1_addr0", addrs[0], 8'h10); chk("t1_addr1", addrs[1], 8'h11); chk("t1_addr2", addrs[2], 8'h12);
      tile(8'h10, 8'd3, 3, -1, -1);
      chk("t2_done_cycle", done_rel, 13); chk("t2_reads", nrd, 3);
      chk("t2_skews", nsk, 10); chk("t2_addr2", addrs[2], 8'h12);
      tile(8'h00, 8'd0, -1, -1, -1);
      chk("t3_done_cycle", done_rel, 1); chk("t3_reads", nrd, 0); chk("t3_skews", nsk, 0);
      tile(8'hFE, 8'd4, -1, -1, -1);
      chk("t4_addr0", addrs[0], 8'hFE); chk("t4_addr1", addrs[1], 8'hFF);
      chk("t4_addr2", addrs[2], 8'h00); chk("t4_addr3", addrs[3], 8'h01);
      chk("t4_done_cycle", done_rel, 13);
      tile(8'h20, 8'd2, -1, 6, -1);
      chk("t5_no_done", done_rel, -1); chk("t5_skews", nsk, 5);
      tile(8'h30, 8'd2, -1, -1, -1);
      chk("t5b_done_cycle", done_rel, 11); chk("t5b_addr0", addrs[0], 8'h30); chk("t5b_addr1", addrs[1], 8'h31);
      s = cyc; start = 1; base = 8'h40; k_len = 8'd5;
      step();
      start = 0;
      step();
      chk("t6_pre_rst_rd_en", rd_en, 1);
      #2 rst = 1;
      #1 chk("t6_async_rd_en", rd_en, 0); chk("t6_async_busy", busy, 0); chk("t6_async_rd_addr", rd_addr, 0);
      step();
      rst = 0;
      step();
      chk("t6_idle_after", busy, 0);
      for (int r = 0; r < 600; r++) begin
         start = ($urandom % 4) == 0; k_len = 8'($urandom % 10); base = 8'($urandom);
         stall = ($urandom % 4) == 0; abort = ($urandom % 40) == 0;
         step();
      end
      start = 0; stall = 0; abort = 0;
      step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
